// File: rtl/rr_burst_arb_pkg.sv
// Shared types and a reference pick function for the round-robin burst arbiter.
package rr_burst_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam int unsigned PICK_MAX_REQ = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First set bit of req scanning ptr, ptr+1, ... modulo n (n <= PICK_MAX_REQ).
  function automatic pick_t rr_pick(input logic [PICK_MAX_REQ-1:0] req,
                                    input int unsigned ptr,
                                    input int unsigned n);
    pick_t       res;
    int unsigned i;
    res = '0;
    for (int unsigned k = 0; k < PICK_MAX_REQ; k++) begin
      i = (ptr + k) % n;
      if (k < n && !res.found && req[i]) begin
        res.found = 1'b1;
        res.idx   = 4'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick_mask.sv
// Combinational round-robin picker: rotate req by ptr, take lowest set bit, unrotate.
module rr_pick_mask #(
  parameter int unsigned  NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rot[i] = req[IDX_W'((32'(ptr) + i) % NUM_REQ)];
    end

    found = |rot;
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end

    // Unrotate: (ptr + off) mod NUM_REQ without a divider.
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting one requester a burst of up to MAX_BURST accepted beats.
module rr_burst_arbiter
  import rr_burst_arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ   = 4,
  parameter int unsigned  MAX_BURST = 4,
  localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1),
  localparam int unsigned IDX_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               burst_last,
  output logic               busy
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               handshake, release_grant, owner_req, grant_new;
  logic [IDX_W-1:0]   next_ptr, pick_ptr, pick_idx;
  logic               pick_found;

  assign owner_req     = req[gnt_id_q];
  assign res_valid     = !rst && |(gnt_q & req);
  assign handshake     = res_valid && res_ready;
  assign burst_last    = handshake && (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign release_grant = (state_q == ARB_GRANT) && (!owner_req || burst_last);
  assign next_ptr      = (gnt_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + IDX_W'(1);
  // On release, re-arbitrate this cycle from the advanced pointer so there is no bubble.
  assign pick_ptr      = release_grant ? next_ptr : rr_ptr_q;

  rr_pick_mask #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    grant_new  = 1'b0;

    unique case (state_q)
      ARB_IDLE: grant_new = pick_found;
      ARB_GRANT: begin
        if (release_grant) begin
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
          if (pick_found) begin
            grant_new = 1'b1;
          end else begin
            state_d  = ARB_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
          end
        end else if (handshake) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
    endcase

    if (grant_new) begin
      state_d  = ARB_GRANT;
      gnt_d    = NUM_REQ'(1) << pick_idx;
      gnt_id_d = pick_idx;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

  pick_t pick_ref;
  assign pick_ref = rr_pick(16'(req), 32'(pick_ptr), NUM_REQ);

  assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  assert property (@(posedge clk) disable iff (rst) ((gnt_q != '0) == busy_q));
  assert property (@(posedge clk) disable iff (rst) (beat_cnt_q < CNT_W'(MAX_BURST)));
  assert property (@(posedge clk) disable iff (rst)
    (pick_ref.found == pick_found) && (!pick_found || pick_ref.idx == 4'(pick_idx)));

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and random traffic vs a model.
module tb_rr_burst_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, res_ready, res_valid, burst_last, busy;
  logic [N-1:0] req, gnt;
  logic [1:0]   gnt_id;

  logic       rst2, ready2, valid2, last2, busy2, gnt_id2;
  logic [1:0] req2, gnt2;

  rr_burst_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_id(gnt_id), .res_valid(res_valid),
    .res_ready(res_ready), .burst_last(burst_last), .busy(busy)
  );

  rr_burst_arbiter #(.NUM_REQ(2), .MAX_BURST(1)) dut2 (
    .clk(clk), .rst(rst2), .req(req2), .gnt(gnt2), .gnt_id(gnt_id2), .res_valid(valid2),
    .res_ready(ready2), .burst_last(last2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference state: current owner (-1 = none), beats accepted in this burst, scan start.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;

  typedef struct {
    logic [N-1:0] req;
    logic         rdy;
    logic [N-1:0] gnt;
    logic [1:0]   id;
    logic         busy;
    logic         valid;
    logic         last;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic check_model(input string tag);
    logic [N-1:0] e_gnt;
    logic         e_valid, e_last;
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    e_valid = !rst && (m_owner >= 0) && req[m_owner];
    e_last  = e_valid && res_ready && (m_beats == MB - 1);
    chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, ".gnt_id"}, 32'(gnt_id), (m_owner >= 0) ? m_owner : 0);
    chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
    chk({tag, ".res_valid"}, 32'(res_valid), 32'(e_valid));
    chk({tag, ".burst_last"}, 32'(burst_last), 32'(e_last));
  endtask

  task automatic model_step();
    bit hs, last;
    hs   = !rst && (m_owner >= 0) && req[m_owner] && res_ready;
    last = hs && (m_beats == MB - 1);
    if (rst) begin
      m_owner = -1;
      m_beats = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      m_owner = model_pick(req, m_ptr);
    end else if (!req[m_owner] || last) begin
      m_ptr   = (m_owner + 1) % N;
      m_beats = 0;
      m_owner = model_pick(req, m_ptr);
    end else if (hs) begin
      m_beats++;
    end
  endtask

  task automatic apply(input logic r, input logic [N-1:0] rq, input logic rdy, input string tag);
    rst = r; req = rq; res_ready = rdy;
    @(negedge clk);
    if (chk_en) check_model(tag);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic rdy, input string tag);
    apply(r, rq, rdy, tag);
    advance();
  endtask

  initial begin
    rst = 1'b1; req = '0; res_ready = 1'b0;
    rst2 = 1'b1; req2 = '0; ready2 = 1'b0;

    tbl[0] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++) begin
        tbl[1 + g*4 + b] = '{4'b1111, 1'b1, 4'(1 << g), 2'(g), 1'b1, 1'b1, 1'(b == 3)};
      end
    end
    tbl[17] = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};

    step(1'b1, '0, 1'b0, "rst");
    step(1'b1, '0, 1'b0, "rst");
    chk_en = 1'b1;

    // All requesting, always ready: 4-beat bursts rotate 0,1,2,3,0 with no gaps.
    foreach (tbl[i]) begin
      apply(1'b0, tbl[i].req, tbl[i].rdy, "tbl");
      chk("tbl.gnt", 32'(gnt), 32'(tbl[i].gnt));
      chk("tbl.gnt_id", 32'(gnt_id), 32'(tbl[i].id));
      chk("tbl.busy", 32'(busy), 32'(tbl[i].busy));
      chk("tbl.res_valid", 32'(res_valid), 32'(tbl[i].valid));
      chk("tbl.burst_last", 32'(burst_last), 32'(tbl[i].last));
      advance();
    end

    // Lone requester 2 with ready toggling: 8 cycles per burst, then a fresh burst.
    step(1'b1, '0, 1'b0, "rst");
    apply(1'b0, 4'b0100, 1'b1, "s2");
    chk("s2.idle_gnt", 32'(gnt), 32'h0);
    advance();
    for (int k = 0; k < 16; k++) begin
      apply(1'b0, 4'b0100, 1'((k % 2) == 0), "s2");
      if (k == 0) chk("s2.gnt_latency", 32'(gnt), 32'b0100);
      if (k == 6 || k == 14) chk("s2.burst_last", 32'(burst_last), 32'h1);
      if (k == 7) chk("s2.regrant", 32'(gnt), 32'b0100);
      advance();
    end

    // Owner 0 drops its request after 2 beats.
    step(1'b1, '0, 1'b0, "rst");
    for (int k = 0; k < 9; k++) begin
      apply(1'b0, (k < 3) ? 4'b0001 : 4'b1010, 1'b1, "s3");
      if (k == 3) chk("s3.drop_last", 32'(burst_last), 32'h0);
      if (k == 4) chk("s3.next_gnt", 32'(gnt), 32'b0010);
      if (k == 4) chk("s3.next_id", 32'(gnt_id), 32'd1);
      advance();
    end

    // req[0] falls right after its 4th handshake: one release, next owner from index 1.
    step(1'b1, '0, 1'b0, "rst");
    for (int k = 0; k < 10; k++) begin
      apply(1'b0, (k < 4) ? 4'b0001 : ((k == 4) ? 4'b0011 : 4'b0010), 1'b1, "s4");
      if (k == 4 || k == 8) chk("s4.burst_last", 32'(burst_last), 32'h1);
      if (k == 5) chk("s4.next_gnt", 32'(gnt), 32'b0010);
      if (k == 9) chk("s4.regrant", 32'(gnt), 32'b0010);
      advance();
    end

    // Reset mid-burst of owner 2.
    step(1'b1, '0, 1'b0, "rst");
    for (int k = 0; k < 6; k++) begin
      apply(k == 3, (k < 4) ? 4'b0100 : 4'b1100, 1'b1, "s5");
      if (k == 3) chk("s5.valid_in_rst", 32'(res_valid), 32'h0);
      if (k == 4) chk("s5.gnt_after_rst", 32'(gnt), 32'h0);
      if (k == 4) chk("s5.busy_after_rst", 32'(busy), 32'h0);
      if (k == 5) chk("s5.first_gnt", 32'(gnt), 32'b0100);
      advance();
    end

    // Random traffic against the reference model.
    step(1'b1, '0, 1'b0, "rst");
    begin
      logic [N-1:0] rq;
      rq = '0;
      for (int k = 0; k < 800; k++) begin
        if ($urandom_range(0, 3) == 0) rq = N'($urandom);
        step(($urandom_range(0, 79) == 0), rq, ($urandom_range(0, 3) != 0), "rand");
      end
    end

    // MAX_BURST=1, two requesters: grant alternates every cycle, burst_last always high.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0; req2 = 2'b11; ready2 = 1'b1;
    @(negedge clk);
    chk("mb1.idle_gnt", 32'(gnt2), 32'h0);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("mb1.gnt", 32'(gnt2), (k % 2 == 1) ? 32'b01 : 32'b10);
      chk("mb1.burst_last", 32'(last2), 32'h1);
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Round-robin arbiter sharing one downstream resource (valid/ready port) among NUM_REQ requesters.
- Each winner holds the grant for up to MAX_BURST accepted beats, or until it drops its request.
- Sits between parameterised client blocks and a single shared datapath or config port; sequences ownership only and carries no data.

Parameters:
- NUM_REQ, 4: number of requesters, legal range 2..16.
- MAX_BURST, 4: max accepted beats per grant, legal range 1..256.
- CNT_W, $clog2(MAX_BURST+1): beat counter width (derived, do not override).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  NUM_REQ  per-requester request level; held high while the requester has beats to send.
- gnt  output  NUM_REQ  one-hot grant, registered.
- gnt_id  output  $clog2(NUM_REQ)  index of current owner, registered; 0 when idle.
- res_valid  output  1  |(gnt & req), combinational from registered gnt.
- res_ready  input  1  resource accepts the beat when res_valid && res_ready.
- burst_last  output  1  combinational; high on the handshake cycle of beat MAX_BURST.
- busy  output  1  registered; high while in GRANT.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values: state=IDLE, gnt=0, gnt_id=0, busy=0, beat_cnt=0, rr_ptr=0 (req[0] highest priority after reset).
- Outputs during reset: res_valid=0 and burst_last=0.
- States: IDLE, GRANT. Encoding comes from the package enum.
- Pick function: first set bit of req scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
- IDLE:
  - If |req: load gnt/gnt_id with the pick, set busy, go to GRANT.
  - Latency: req high in cycle t produces gnt in cycle t+1.
- GRANT, handshake (res_valid && res_ready): beat_cnt increments.
- GRANT, release condition (any one):
  - (a) req[gnt_id]==0.
  - (b) handshake with beat_cnt==MAX_BURST-1; burst_last=1 in this cycle.
- On release in cycle t:
  - rr_ptr <= gnt_id+1 (wrap).
  - beat_cnt <= 0.
  - Re-arbitrate in the same cycle using the updated pointer on the current req. Any new grant is visible at t+1 (no bubble).
  - No req to pick: gnt=0, busy=0, go to IDLE.
- Single-requester case: the previous owner may re-win immediately when no other req is set, with a fresh burst count.
- Simultaneous (a) and (b): one release only, treated identically.
- Owner drops req without any handshake: release with zero beats; the pointer still advances.
- Non-owner req changes during GRANT: no effect until the next arbitration.
- res_ready is ignored whenever res_valid=0. The handshake is never counted when the owner's req is low.
- MAX_BURST=1: every accepted beat releases; burst_last == handshake.
- rst asserted mid-burst: next cycle all reset values apply. The in-flight beat is not counted; rr_ptr returns to 0.
- Assertions: gnt is one-hot or zero; gnt!=0 iff busy; beat_cnt never exceeds MAX_BURST-1.

Decomposition:
- Package rr_burst_arb_pkg holds:
  - state enum arb_state_e {ARB_IDLE, ARB_GRANT}.
  - Pure function rr_pick(req, ptr) returning index and a found flag.
- One natural sub-module: rr_pick_mask, the combinational rotate/priority-encode/unrotate picker. It is instantiated once and parameterised by NUM_REQ.

Test Plan:
- After reset (NUM_REQ=4, MAX_BURST=4), drive req=4'b1111 with res_ready=1 constantly:
  - Expected grant sequence is gnt 0001 for 4 beats, then 0010, 0100, 1000, 0001.
  - burst_last pulses every 4th beat.
  - No idle cycle between grants.
- req=4'b0100 alone with res_ready toggling 1,0,1,0:
  - gnt=0100 one cycle after req.
  - The 4 beats take 8 cycles; then gnt is re-granted to 0100 with beat_cnt reset.
- Owner 0 granted, req[0] dropped after 2 beats while req=4'b1010:
  - Next gnt=0010 the cycle after the drop.
  - rr_ptr=1; burst_last never asserted.
- req[0] drops on the same cycle as its 4th handshake:
  - Exactly one release; burst_last=1 in that cycle.
  - Next owner is picked starting from index 1.
- rst pulsed on beat 2 of owner 2:
  - Next cycle gnt=0, busy=0, res_valid=0.
  - With req=4'b1100 after reset, the first grant is 0100 (pointer back at 0).
- MAX_BURST=1, NUM_REQ=2, req=2'b11, res_ready=1:
  - gnt alternates 01,10 every cycle.
  - burst_last is high on every cycle.
